// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin system-bus arbiter: FSM states,
// default sizing and the owner-index width helper.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int DEFAULT_NUM_MASTERS = 2;
    localparam int DEFAULT_MAX_HOLD    = 4096;

    // A single master still needs a one-bit owner index.
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: the request vector is doubled and rotated
// by the pointer, and the lowest set bit of the rotated view wins.
module rr_pick
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
    parameter int OWNER_W     = owner_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [OWNER_W-1:0]     rr_ptr,
    output logic [OWNER_W-1:0]     winner,
    output logic                   any
);

    localparam logic [OWNER_W:0] NUM_M = (OWNER_W+1)'(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] req_rot;
    logic [OWNER_W-1:0]     offset;
    logic [OWNER_W:0]       sum;

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        req_rot = NUM_MASTERS'({req, req} >> rr_ptr);
        offset  = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = OWNER_W'(i);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= NUM_M) begin
            sum = sum - NUM_M;
        end
        winner = sum[OWNER_W-1:0];
    end

    assign any = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the serial system bus with a one-cycle turnaround
// between owners and a hold-time watchdog that revokes a stalled grant.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
    parameter int MAX_HOLD    = DEFAULT_MAX_HOLD,
    parameter int OWNER_W     = owner_width(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] done,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [NUM_MASTERS-1:0] busy,
    output logic [OWNER_W-1:0]     owner,
    output logic                   owner_valid,
    output logic                   timeout
);

    localparam int                 HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0]  HOLD_SAT  = HOLD_W'(MAX_HOLD);
    localparam logic [OWNER_W-1:0] LAST_IDX  = OWNER_W'(NUM_MASTERS - 1);

    state_e                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] busy_q;
    logic [OWNER_W-1:0]     owner_q;
    logic [OWNER_W-1:0]     rr_ptr_q;
    logic [HOLD_W-1:0]      hold_q;
    logic                   timeout_q;

    logic [OWNER_W-1:0]     win_idx;
    logic                   win_any;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic                   rel_done;
    logic                   rel_req;
    logic                   rel_wd;
    logic                   release_now;
    logic [OWNER_W-1:0]     rr_ptr_d;
    logic [HOLD_W-1:0]      hold_d;

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .OWNER_W     (OWNER_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (win_idx),
        .any    (win_any)
    );

    always_comb begin
        win_onehot  = NUM_MASTERS'(1) << win_idx;
        rel_done    = done[owner_q];
        rel_req     = ~req[owner_q];
        rel_wd      = (hold_q == HOLD_LAST);
        release_now = rel_done | rel_req | rel_wd;
        rr_ptr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + OWNER_W'(1);
        hold_d      = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busy_q    <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                OWNED: begin
                    if (release_now) begin
                        state_q   <= RELEASE;
                        grant_q   <= '0;
                        busy_q    <= '1;
                        rr_ptr_q  <= rr_ptr_d;
                        // A done strobe or dropped request wins over a coincident expiry.
                        timeout_q <= rel_wd & ~rel_done & ~rel_req;
                    end else begin
                        hold_q <= hold_d;
                    end
                end
                default: begin
                    if (win_any) begin
                        state_q <= OWNED;
                        owner_q <= win_idx;
                        grant_q <= win_onehot;
                        busy_q  <= ~win_onehot;
                        hold_q  <= '0;
                    end else begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= '0;
                    end
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign owner_valid = |grant_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios on a 2-master/16-cycle instance and
// a randomized run on a 4-master/8-cycle instance against a transaction-level model.
module tb_bus_arbiter;

    localparam int NA = 2;
    localparam int HA = 16;
    localparam int WA = 1;
    localparam int NB = 4;
    localparam int HB = 8;
    localparam int WB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_a;
    logic [NA-1:0] req_a, done_a, grant_a, busy_a;
    logic [WA-1:0] owner_a;
    logic          ov_a, to_a;

    logic          reset_b;
    logic [NB-1:0] req_b, done_b, grant_b, busy_b;
    logic [WB-1:0] owner_b;
    logic          ov_b, to_b;

    int n_checks = 0;
    int n_errors = 0;

    bus_arbiter #(.NUM_MASTERS(NA), .MAX_HOLD(HA)) u_dut_a (
        .clk(clk), .reset(reset_a), .req(req_a), .done(done_a),
        .grant(grant_a), .busy(busy_a), .owner(owner_a),
        .owner_valid(ov_a), .timeout(to_a)
    );

    bus_arbiter #(.NUM_MASTERS(NB), .MAX_HOLD(HB)) u_dut_b (
        .clk(clk), .reset(reset_b), .req(req_b), .done(done_b),
        .grant(grant_b), .busy(busy_b), .owner(owner_b),
        .owner_valid(ov_b), .timeout(to_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut_a();
        reset_a = 1'b1; req_a = '0; done_a = '0;
        tick();
        reset_a = 1'b0;
    endtask

    task automatic test_reset();
        reset_a = 1'b1; req_a = '1; done_a = '0;
        tick(); tick();
        n_checks++;
        if ({grant_a, busy_a, owner_a, ov_a, to_a} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: grant=%b busy=%b owner=%0d valid=%b timeout=%b, want all zero",
                     grant_a, busy_a, owner_a, ov_a, to_a);
        end
        reset_a = 1'b0; req_a = '0;
        tick();
    endtask

    task automatic test_basic();
        req_a = 2'b01;
        tick();
        n_checks++;
        if (grant_a !== 2'b01 || ov_a !== 1'b1 || busy_a !== 2'b10 || owner_a !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_grant: grant=%b valid=%b busy=%b owner=%0d, want 01 1 10 0",
                     grant_a, ov_a, busy_a, owner_a);
        end
        repeat (3) tick();
        n_checks++;
        if (grant_a !== 2'b01) begin
            n_errors++;
            $display("FAIL basic_hold: grant=%b, want 01", grant_a);
        end
        done_a = 2'b01;
        tick();
        done_a = '0; req_a = '0;
        n_checks++;
        if (grant_a !== 2'b00 || busy_a !== 2'b11 || ov_a !== 1'b0 || to_a !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_release: grant=%b busy=%b valid=%b timeout=%b, want 00 11 0 0",
                     grant_a, busy_a, ov_a, to_a);
        end
        tick();
        n_checks++;
        if (grant_a !== 2'b00 || busy_a !== 2'b00 || owner_a !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_idle: grant=%b busy=%b owner=%0d, want 00 00 0", grant_a, busy_a, owner_a);
        end
    endtask

    task automatic test_alternate();
        logic [NA-1:0] exp_g;
        reset_dut_a();
        req_a = 2'b11;
        exp_g = 2'b01;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (grant_a !== exp_g) begin
                n_errors++;
                $display("FAIL alt_grant%0d: grant=%b, want %b", k, grant_a, exp_g);
            end
            repeat (4) tick();
            n_checks++;
            if (grant_a !== exp_g) begin
                n_errors++;
                $display("FAIL alt_hold%0d: grant=%b, want %b", k, grant_a, exp_g);
            end
            done_a = exp_g;
            tick();
            done_a = '0;
            n_checks++;
            if (grant_a !== 2'b00 || busy_a !== 2'b11) begin
                n_errors++;
                $display("FAIL alt_gap%0d: grant=%b busy=%b, want 00 11", k, grant_a, busy_a);
            end
            tick();
            exp_g = ~exp_g;
        end
        req_a = '0;
        tick(); tick();
    endtask

    task automatic test_watchdog();
        int  cnt;
        int  early_to;
        bit  dropped;
        reset_dut_a();
        req_a = 2'b01;
        tick();
        cnt = 0; early_to = 0; dropped = 1'b0;
        for (int t = 0; t < 40 && !dropped; t++) begin
            tick();
            cnt++;
            if (grant_a === 2'b00) dropped = 1'b1;
            else if (to_a !== 1'b0) early_to++;
        end
        n_checks++;
        if (!dropped || cnt != HA) begin
            n_errors++;
            $display("FAIL wd_hold_len: held %0d cycles (dropped=%0b), want %0d", cnt, dropped, HA);
        end
        n_checks++;
        if (to_a !== 1'b1 || early_to != 0) begin
            n_errors++;
            $display("FAIL wd_timeout: timeout=%b early_pulses=%0d, want 1 0", to_a, early_to);
        end
        tick();
        n_checks++;
        if (grant_a !== 2'b01 || to_a !== 1'b0) begin
            n_errors++;
            $display("FAIL wd_regrant: grant=%b timeout=%b, want 01 0", grant_a, to_a);
        end
        repeat (HA - 1) tick();
        n_checks++;
        if (grant_a !== 2'b01) begin
            n_errors++;
            $display("FAIL wd_last_cycle: grant=%b, want 01", grant_a);
        end
        done_a = 2'b01;
        tick();
        done_a = '0; req_a = '0;
        n_checks++;
        if (grant_a !== 2'b00 || to_a !== 1'b0) begin
            n_errors++;
            $display("FAIL wd_done_coincide: grant=%b timeout=%b, want 00 0", grant_a, to_a);
        end
        tick();
    endtask

    task automatic test_req_drop();
        reset_dut_a();
        req_a = 2'b11;
        tick(); tick();
        req_a = 2'b10;
        tick();
        n_checks++;
        if (grant_a !== 2'b00 || busy_a !== 2'b11 || to_a !== 1'b0) begin
            n_errors++;
            $display("FAIL drop_release: grant=%b busy=%b timeout=%b, want 00 11 0", grant_a, busy_a, to_a);
        end
        tick();
        n_checks++;
        if (grant_a !== 2'b10 || owner_a !== 1'b1 || busy_a !== 2'b01 || to_a !== 1'b0) begin
            n_errors++;
            $display("FAIL drop_next: grant=%b owner=%0d busy=%b timeout=%b, want 10 1 01 0",
                     grant_a, owner_a, busy_a, to_a);
        end
        req_a = '0;
        tick(); tick();
    endtask

    task automatic test_foreign_done();
        reset_dut_a();
        req_a = 2'b01;
        tick();
        done_a = 2'b10;
        tick();
        done_a = '0;
        tick();
        n_checks++;
        if (grant_a !== 2'b01 || busy_a !== 2'b10) begin
            n_errors++;
            $display("FAIL foreign_done: grant=%b busy=%b, want 01 10", grant_a, busy_a);
        end
        req_a = '0;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        reset_dut_a();
        req_a = 2'b11;
        tick();
        done_a = 2'b01;
        tick();
        done_a = '0;
        tick();
        n_checks++;
        if (grant_a !== 2'b10 || owner_a !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_setup: grant=%b owner=%0d, want 10 1", grant_a, owner_a);
        end
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        n_checks++;
        if ({grant_a, busy_a, owner_a, ov_a, to_a} !== '0) begin
            n_errors++;
            $display("FAIL midrst_outputs: grant=%b busy=%b owner=%0d valid=%b timeout=%b, want all zero",
                     grant_a, busy_a, owner_a, ov_a, to_a);
        end
        tick();
        n_checks++;
        if (grant_a !== 2'b01 || owner_a !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_priority: grant=%b owner=%0d, want 01 0", grant_a, owner_a);
        end
        req_a = '0;
        tick(); tick();
    endtask

    // Model: an owner index (or none), a turnaround flag, a hold count and the
    // rotating priority start; winners are found by a modular upward search.
    task automatic test_random();
        logic [NB-1:0] r, d, e_grant, e_busy;
        bit            rst, rel_d, rel_r, rel_w, e_to;
        int            m_owner, m_ptr, m_held, m_out, idx;
        bit            m_turn;
        reset_b = 1'b1; req_b = '0; done_b = '0;
        tick();
        m_owner = -1; m_ptr = 0; m_held = 0; m_out = 0; m_turn = 1'b0;
        r = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(7) == 0) r[i] = ~r[i];
                d[i] = ($urandom_range(9) == 0);
            end
            rst = ($urandom_range(99) == 0);
            req_b = r; done_b = d; reset_b = rst;
            e_to = 1'b0;
            if (rst) begin
                m_owner = -1; m_ptr = 0; m_held = 0; m_out = 0; m_turn = 1'b0;
            end else if (m_owner >= 0) begin
                rel_d = d[m_owner];
                rel_r = !r[m_owner];
                rel_w = (m_held == HB - 1);
                if (rel_d || rel_r || rel_w) begin
                    e_to    = rel_w && !rel_d && !rel_r;
                    m_ptr   = (m_owner + 1) % NB;
                    m_owner = -1;
                    m_turn  = 1'b1;
                end else begin
                    m_held++;
                end
            end else begin
                m_turn = 1'b0;
                for (int k = 0; k < NB; k++) begin
                    idx = (m_ptr + k) % NB;
                    if (r[idx] && m_owner < 0) begin
                        m_owner = idx; m_out = idx; m_held = 0;
                    end
                end
            end
            e_grant = (m_owner >= 0) ? (NB'(1) << m_owner) : '0;
            e_busy  = (m_owner >= 0) ? ~e_grant : (m_turn ? '1 : '0);
            tick();
            n_checks++;
            if (grant_b !== e_grant || busy_b !== e_busy || ov_b !== (m_owner >= 0)) begin
                n_errors++;
                $display("FAIL rand_grant c=%0d: grant=%b busy=%b valid=%b, want %b %b %b",
                         c, grant_b, busy_b, ov_b, e_grant, e_busy, (m_owner >= 0));
            end
            n_checks++;
            if (owner_b !== WB'(m_out) || to_b !== e_to) begin
                n_errors++;
                $display("FAIL rand_owner c=%0d: owner=%0d timeout=%b, want %0d %b",
                         c, owner_b, to_b, m_out, e_to);
            end
        end
        reset_b = 1'b0; req_b = '0; done_b = '0;
    endtask

    initial begin
        reset_a = 1'b1; req_a = '0; done_a = '0;
        reset_b = 1'b1; req_b = '0; done_b = '0;
        test_reset();
        test_basic();
        test_alternate();
        test_watchdog();
        test_req_drop();
        test_foreign_done();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
